bus_arbiter_demux: RTL
======================

# bus_arbiter_demux

Round-robin arbiter and response demultiplexer that owns the shared side of a `mux_bus`-style port bus. It picks one of NUM_PORTS requesters and drives the mux select (`enable_port`/`valid_enable`). It holds that grant until the shared resource signals completion, then steers the returned data word and a done pulse back to the granted port only. It sits between per-port clients (e.g. cache-side requesters) and a single shared responder.

## Interface
- `WIDTH`, default 8: response data width per port.
- `NUM_PORTS`, default 4: number of requesters. Must be ≥ 2. Select width is log2(NUM_PORTS), using the team's ceiling-log2 function.
- `clock`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `request`  in  NUM_PORTS  bit i high = port i wants the bus. Held high until that port sees its `done_out` bit.
- `bus_done`  in  1  shared responder completion strobe; `bus_data_in` is valid in the same cycle.
- `bus_data_in`  in  WIDTH  response word from the shared responder.
- `enable_port`  out  log2(NUM_PORTS)  index of the granted port (mux select).
- `valid_enable`  out  1  high while a grant is active.
- `data_out`  out  WIDTH*NUM_PORTS  registered per-port response; slice i = `data_out[i*WIDTH +: WIDTH]`.
- `done_out`  out  NUM_PORTS  one-cycle, one-hot completion pulse to the granted port.

## Operation
- **State machine:** IDLE, BUSY, RELEASE. All outputs are registered.
- **IDLE:**
  - If `request` is nonzero, choose the first set bit scanning upward, with wrap, starting at `last_grant+1` (mod NUM_PORTS).
  - Register the choice into `enable_port` and `last_grant`, set `valid_enable`=1, and go to BUSY.
  - If `request` is zero, stay in IDLE.
- **BUSY:**
  - Hold `enable_port`/`valid_enable` stable.
  - On `bus_done`=1: write `bus_data_in` into the `enable_port` slice of `data_out`, set `done_out[enable_port]`=1, clear `valid_enable`, and go to RELEASE.
  - All other `data_out` slices hold their value.
- **RELEASE:**
  - Lasts one cycle. `done_out` is high during this cycle only; the client deasserts its request on the following edge.
  - Next state is IDLE; `done_out` clears.
- **Ignored conditions:**
  - `bus_done` in IDLE or RELEASE is ignored.
  - Request changes during BUSY are ignored: the grant is never aborted, and a dropped request still completes.
- **Fairness:**
  - The pointer advances only on grant.
  - With all ports requesting continuously, grants cycle 0,1,…,NUM_PORTS-1,0.
  - A port waits at most NUM_PORTS-1 transactions.
- **Reset (asynchronous, immediate, mid-transaction included):**
  - State returns to IDLE; `valid_enable`, `enable_port`, `done_out` and all of `data_out` go to 0.
  - `last_grant` is set to NUM_PORTS-1, so port 0 has priority first.
  - No pending completion is delivered after reset.

## Timing
- **Grant latency:** request high in IDLE during cycle n gives `valid_enable`/`enable_port` valid from cycle n+1.
- **Completion:** `bus_done` in BUSY cycle k gives `data_out` slice and `done_out` valid in cycle k+1 (RELEASE), and IDLE in cycle k+2.
- **Back-to-back:** the earliest next grant is visible in cycle k+3. A minimum transaction (bus_done in the first BUSY cycle) is 3 cycles grant-to-grant.
- **Done pulse:** `done_out` is exactly one cycle wide and never has more than one bit set.
- **Select stability:** `enable_port` changes only on the IDLE→BUSY edge. It holds its last value after release; consumers must qualify it with `valid_enable`.

## Test plan
- **Reset values:** assert `reset` asynchronously mid-cycle → all outputs 0 immediately; after release with `request`=0 → `valid_enable` stays 0.
- **Single port:** `request`=4'b0100, `bus_done` pulsed 3 cycles after grant with `bus_data_in`=8'hA5 → `enable_port`=2 and `valid_enable`=1 one cycle after request; `data_out[23:16]`=8'hA5 and `done_out`=4'b0100 for exactly one cycle; other slices unchanged.
- **Round robin:** `request`=4'b1111 held, with each client dropping its bit after its done → grants in order 0,1,2,3; with bits re-raised, order 0,1,2,3 again; each grant spaced 3 cycles with immediate `bus_done`.
- **Wrap/skip:** after a grant to port 3, `request`=4'b0110 → next grant is port 1; then `request`=4'b0001 → grant is port 0.
- **Spurious inputs:** `bus_done`=1 while IDLE with `bus_data_in`=8'hFF → no `data_out` or `done_out` change. Drop the granted request mid-BUSY, then `bus_done` → transaction still completes and the done pulse still fires.
- **Reset mid-BUSY:** grant port 1, assert `reset` before `bus_done` → `valid_enable`=0 at once; after release, `request`=4'b0011 → port 0 is granted first.

Source files
------------

// File: rtl/bus_arbiter_demux.sv
// rtl/bus_arbiter_demux.sv - round-robin bus arbiter with registered per-port response demux
module bus_arbiter_demux #(
  parameter int WIDTH     = 8,
  parameter int NUM_PORTS = 4
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [NUM_PORTS-1:0]           request,
  input  logic                           bus_done,
  input  logic [WIDTH-1:0]               bus_data_in,
  output logic [$clog2(NUM_PORTS)-1:0]   enable_port,
  output logic                           valid_enable,
  output logic [WIDTH*NUM_PORTS-1:0]     data_out,
  output logic [NUM_PORTS-1:0]           done_out
);

  localparam int SEL_W = $clog2(NUM_PORTS);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_BUSY    = 2'd1,
    S_RELEASE = 2'd2
  } state_t;

  state_t                     r_state;
  state_t                     w_state_nxt;

  logic [SEL_W-1:0]           r_enable_port;
  logic [SEL_W-1:0]           r_last_grant;
  logic                       r_valid_enable;
  logic [WIDTH*NUM_PORTS-1:0] r_data_out;
  logic [NUM_PORTS-1:0]       r_done_out;

  logic [SEL_W-1:0]           w_enable_port_nxt;
  logic [SEL_W-1:0]           w_last_grant_nxt;
  logic                       w_valid_enable_nxt;
  logic [WIDTH*NUM_PORTS-1:0] w_data_out_nxt;
  logic [NUM_PORTS-1:0]       w_done_out_nxt;

  logic [SEL_W-1:0]           w_pick;
  logic                       w_found;

  // Round-robin pick: first requesting port scanning upward from last_grant+1, wrapping
  always_comb begin
    w_pick  = '0;
    w_found = 1'b0;
    for (int i = 1; i <= NUM_PORTS; i++) begin
      if (!w_found && request[(int'(r_last_grant) + i) % NUM_PORTS]) begin
        w_pick  = SEL_W'((int'(r_last_grant) + i) % NUM_PORTS);
        w_found = 1'b1;
      end
    end
  end

  // State register; reset is asynchronous so a pending completion is dropped at once
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: a grant is never aborted once BUSY, RELEASE is always one cycle
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (|request) w_state_nxt = S_BUSY;
      S_BUSY:    if (bus_done) w_state_nxt = S_RELEASE;
      S_RELEASE: w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  // Output logic: next values of the registered outputs; done_out defaults low so it pulses
  always_comb begin
    w_enable_port_nxt  = r_enable_port;
    w_last_grant_nxt   = r_last_grant;
    w_valid_enable_nxt = r_valid_enable;
    w_data_out_nxt     = r_data_out;
    w_done_out_nxt     = '0;
    case (r_state)
      S_IDLE: begin
        if (|request) begin
          w_enable_port_nxt  = w_pick;
          w_last_grant_nxt   = w_pick;
          w_valid_enable_nxt = 1'b1;
        end
      end
      S_BUSY: begin
        if (bus_done) begin
          w_data_out_nxt[int'(r_enable_port)*WIDTH +: WIDTH] = bus_data_in;
          w_done_out_nxt[r_enable_port]                      = 1'b1;
          w_valid_enable_nxt                                 = 1'b0;
        end
      end
      default: begin
        w_valid_enable_nxt = 1'b0;
      end
    endcase
  end

  // Output registers; last_grant resets to the top port so port 0 wins first
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_enable_port  <= '0;
      r_last_grant   <= SEL_W'(NUM_PORTS - 1);
      r_valid_enable <= 1'b0;
      r_data_out     <= '0;
      r_done_out     <= '0;
    end else begin
      r_enable_port  <= w_enable_port_nxt;
      r_last_grant   <= w_last_grant_nxt;
      r_valid_enable <= w_valid_enable_nxt;
      r_data_out     <= w_data_out_nxt;
      r_done_out     <= w_done_out_nxt;
    end
  end

  assign enable_port  = r_enable_port;
  assign valid_enable = r_valid_enable;
  assign data_out     = r_data_out;
  assign done_out     = r_done_out;

endmodule
